sram_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port async SRAM arbiter.
// States, bus widths and owner encoding.
package sram_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_e;

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter.sv
// Video/host arbiter and cycle sequencer for a 512Kx16 async SRAM.
// Optional host starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACC_CYCLES = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc
    $error("ACC_CYCLES out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range");
  end

  localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

  state_e              state_q, state_d;
  owner_e              own_q, own_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                drive_q, drive_d;
  logic [DATA_W-1:0]   vrd_q, vrd_d;
  logic [DATA_W-1:0]   hrd_q, hrd_d;
  logic                vval_q, vval_d;
  logic                hval_q, hval_d;
  logic                host_win;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  assign host_win = host_req &&
                    (!vid_req || starve_q >= STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (!host_req || host_ack)
      starve_d = '0;
    else if (vid_ack && starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign host_win = host_req && !vid_req;
`endif

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    vrd_d    = vrd_q;
    hrd_d    = hrd_q;
    vval_d   = 1'b0;
    hval_d   = 1'b0;
    vid_ack  = 1'b0;
    host_ack = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (vid_req && !host_win) begin
          vid_ack = 1'b1;
          own_d   = OWN_VID;
          addr_d  = vid_addr;
          be_d    = 2'b11;
          cnt_d   = '0;
          state_d = S_RD;
        end else if (host_req) begin
          host_ack = 1'b1;
          own_d    = OWN_HOST;
          addr_d   = host_addr;
          wdata_d  = host_wdata;
          be_d     = host_be;
          cnt_d    = '0;
          state_d  = host_we ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == ACC_LAST) begin
          state_d = S_IDLE;
          if (own_q == OWN_VID) begin
            vrd_d  = sram_dq;
            vval_d = 1'b1;
          end else begin
            hrd_d  = sram_dq;
            hval_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == ACC_LAST) state_d = S_WR_HOLD;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_WR_HOLD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so pins never glitch.
    oe_n_d  = (state_d != S_RD);
    we_n_d  = (state_d != S_WR_PULSE);
    drive_d = (state_d == S_WR_SETUP) ||
              (state_d == S_WR_PULSE) ||
              (state_d == S_WR_HOLD);
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    if (state_d == S_RD) begin
      ub_n_d = 1'b0;
      lb_n_d = 1'b0;
    end else if (drive_d) begin
      ub_n_d = ~be_d[1];
      lb_n_d = ~be_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= OWN_VID;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      drive_q <= 1'b0;
      vrd_q   <= '0;
      hrd_q   <= '0;
      vval_q  <= 1'b0;
      hval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      drive_q <= drive_d;
      vrd_q   <= vrd_d;
      hrd_q   <= hrd_d;
      vval_q  <= vval_d;
      hval_q  <= hval_d;
    end
  end

  assign sram_dq     = drive_q ? wdata_q : 'z;
  assign sram_addr   = addr_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;
  assign vid_rdata   = vrd_q;
  assign vid_rvalid  = vval_q;
  assign host_rdata  = hrd_q;
  assign host_rvalid = hval_q;

endmodule
